dmem_responder: RTL and testbench

- Data-memory responder serving load/store requests issued by the memory-access pipeline stage.
- Accepts one request at a time over a valid/ready request channel and returns one response over a valid/ready response channel.
- Response latency is configurable through wait states.
- Supports byte, half-word and word accesses on a word-organised array, with misalignment and range checking.

---
 rtl/dmem_responder.sv | 210 +++++++++++++++++++++
 tb/tb_dmem_responder.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Brief    : Word-organised data memory answering one load/store at a time
//            over valid/ready request and response channels. Response latency
//            is set by WAIT_CYCLES. Byte, half-word and word accesses are
//            supported, with misalignment, range and size checking.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned c_AW        = $clog2(DEPTH_WORDS);
    localparam logic [32:0] c_SPAN      = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  c_WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t       r_state;
    state_t       w_state_next;
    logic [1:0]   r_rst_sync;
    logic         w_rst_n;
    logic [3:0]   r_cnt;
    logic [31:0]  r_addr;
    logic         r_write;
    logic [1:0]   r_size;
    logic [31:0]  r_wdata;
    logic [31:0]  r_rdata;
    logic         r_err;
    logic [31:0]  r_mem [DEPTH_WORDS];

    logic         w_req_ready;
    logic         w_resp_valid;
    logic         w_accept;
    logic         w_enter_resp;
    logic [31:0]  w_cur_addr;
    logic         w_cur_write;
    logic [1:0]   w_cur_size;
    logic [31:0]  w_cur_wdata;
    logic [31:0]  w_offset;
    logic [1:0]   w_lane;
    logic [c_AW-1:0] w_idx;
    logic         w_misaligned;
    logic         w_out_of_range;
    logic         w_err;
    logic [3:0]   w_be;
    logic [31:0]  w_wdata_sh;
    logic [31:0]  w_rshift;
    logic [31:0]  w_load_data;

    // Reset synchroniser: assertion is immediate, release is aligned to clk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    // Next-state and handshake decode
    always_comb begin
        w_state_next = r_state;
        w_req_ready  = 1'b0;
        w_resp_valid = 1'b0;
        w_accept     = 1'b0;
        w_enter_resp = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_req_ready = 1'b1;
                if (req_valid) begin
                    w_accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        w_state_next = ST_RESP;
                        w_enter_resp = 1'b1;
                    end else begin
                        w_state_next = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                if (r_cnt == 4'd0) begin
                    w_state_next = ST_RESP;
                    w_enter_resp = 1'b1;
                end
            end
            ST_RESP: begin
                w_resp_valid = 1'b1;
                if (resp_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // With zero wait states the access completes on the acceptance edge, so
    // the live request is used in IDLE and the latched copy otherwise.
    assign w_cur_addr  = (r_state == ST_IDLE) ? req_addr  : r_addr;
    assign w_cur_write = (r_state == ST_IDLE) ? req_write : r_write;
    assign w_cur_size  = (r_state == ST_IDLE) ? req_size  : r_size;
    assign w_cur_wdata = (r_state == ST_IDLE) ? req_wdata : r_wdata;

    // BASE_ADDR is aligned to the array span, so the offset's low bits equal
    // the address's byte lane.
    assign w_offset       = w_cur_addr - BASE_ADDR;
    assign w_lane         = w_offset[1:0];
    assign w_idx          = w_offset[c_AW+1:2];
    assign w_out_of_range = ({1'b0, w_offset} >= c_SPAN);
    assign w_misaligned   = ((w_cur_size == 2'b01) && w_lane[0]) ||
                            ((w_cur_size == 2'b10) && (w_lane != 2'b00));
    assign w_err          = w_out_of_range || w_misaligned || (w_cur_size == 2'b11);

    // Byte enables and lane-aligned store data
    always_comb begin
        w_be = 4'b0000;
        case (w_cur_size)
            2'b00:   w_be = 4'b0001 << w_lane;
            2'b01:   w_be = w_lane[1] ? 4'b1100 : 4'b0011;
            2'b10:   w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    assign w_wdata_sh = w_cur_wdata << {w_lane, 3'b000};
    assign w_rshift   = r_mem[w_idx] >> {w_lane, 3'b000};

    // Load data: right-aligned, zero-extended to the access width
    always_comb begin
        w_load_data = 32'h0000_0000;
        case (w_cur_size)
            2'b00:   w_load_data = {24'h000000, w_rshift[7:0]};
            2'b01:   w_load_data = {16'h0000, w_rshift[15:0]};
            2'b10:   w_load_data = w_rshift;
            default: w_load_data = 32'h0000_0000;
        endcase
    end

    // Control state, request latch, wait counter and response registers
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_addr  <= 32'h0000_0000;
            r_write <= 1'b0;
            r_size  <= 2'b00;
            r_wdata <= 32'h0000_0000;
            r_rdata <= 32'h0000_0000;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_addr  <= req_addr;
                r_write <= req_write;
                r_size  <= req_size;
                r_wdata <= req_wdata;
                r_cnt   <= c_WAIT_LOAD;
            end else if ((r_state == ST_BUSY) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_enter_resp) begin
                r_err   <= w_err;
                r_rdata <= (w_err || w_cur_write) ? 32'h0000_0000 : w_load_data;
            end else if ((r_state == ST_RESP) && resp_ready) begin
                r_err   <= 1'b0;
                r_rdata <= 32'h0000_0000;
            end
        end
    end

    // Store commit on entry to RESP; contents survive reset, and nothing is
    // written while reset is held.
    always_ff @(posedge clk) begin
        if (w_rst_n && w_enter_resp && w_cur_write && !w_err) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wdata_sh[8*i +: 8];
                end
            end
        end
    end

    assign req_ready  = w_req_ready;
    assign resp_valid = w_resp_valid;
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Brief    : Self-checking bench for dmem_responder. Three instances with
//            different wait-state counts and base addresses share one request
//            bus; a byte-array model predicts every response.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    logic        clk;
    logic        rst_n;
    logic [2:0]  req_valid_v;
    logic [2:0]  req_ready_v;
    logic [31:0] req_addr;
    logic        req_write;
    logic [1:0]  req_size;
    logic [31:0] req_wdata;
    logic [2:0]  resp_valid_v;
    logic        resp_ready;
    logic [31:0] resp_rdata_v [3];
    logic [2:0]  resp_err_v;

    int n_cmp = 0;
    int n_bad = 0;

    // Byte-level reference memory per instance
    logic [7:0] mm [3][256];

    typedef struct {
        int          d;
        logic        wr;
        logic [1:0]  sz;
        logic [31:0] addr;
        logic [31:0] wd;
        int          hold;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vt [22];

    function automatic int wait_of(input int d);
        case (d)
            0:       return 1;
            1:       return 3;
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] base_of(input int d);
        return (d == 2) ? 32'h0000_0400 : 32'h0000_0000;
    endfunction

    function automatic int depth_of(input int d);
        return (d == 2) ? 16 : 64;
    endfunction

    dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(1), .BASE_ADDR(32'h0000_0000)) u_dut_w1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid_v[0]), .req_ready(req_ready_v[0]),
        .req_addr(req_addr), .req_write(req_write), .req_size(req_size), .req_wdata(req_wdata),
        .resp_valid(resp_valid_v[0]), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata_v[0]), .resp_err(resp_err_v[0])
    );

    dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(3), .BASE_ADDR(32'h0000_0000)) u_dut_w3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid_v[1]), .req_ready(req_ready_v[1]),
        .req_addr(req_addr), .req_write(req_write), .req_size(req_size), .req_wdata(req_wdata),
        .resp_valid(resp_valid_v[1]), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata_v[1]), .resp_err(resp_err_v[1])
    );

    dmem_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(0), .BASE_ADDR(32'h0000_0400)) u_dut_w0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid_v[2]), .req_ready(req_ready_v[2]),
        .req_addr(req_addr), .req_write(req_write), .req_size(req_size), .req_wdata(req_wdata),
        .resp_valid(resp_valid_v[2]), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata_v[2]), .resp_err(resp_err_v[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: actual=still running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Reference model: error rules and byte-array access
    task automatic model_op(input int d, input logic wr, input logic [1:0] sz,
                            input logic [31:0] a, input logic [31:0] wd,
                            output logic [31:0] rd, output logic er);
        logic [31:0] off;
        int n;
        off = a - base_of(d);
        er  = (sz == 2'b11) || ((sz == 2'b01) && a[0]) || ((sz == 2'b10) && (a[1:0] != 2'b00)) ||
              (off >= 32'(depth_of(d) * 4));
        rd  = 32'h0;
        if (!er) begin
            n = 1 << sz;
            for (int i = 0; i < n; i++) begin
                if (wr) mm[d][int'(off) + i] = wd[8*i +: 8];
                else    rd[8*i +: 8] = mm[d][int'(off) + i];
            end
        end
    endtask

    // One full transaction with latency, backpressure and handshake checks
    task automatic do_req(input int d, input logic wr, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] wd, input int hold,
                          input logic [31:0] exp_rd, input logic exp_err, input string nm);
        int lat;
        @(negedge clk);
        check($sformatf("%s/ready_idle", nm), 32'(req_ready_v[d]), 32'd1);
        req_addr       = a;
        req_write      = wr;
        req_size       = sz;
        req_wdata      = wd;
        req_valid_v[d] = 1'b1;
        @(posedge clk);
        #1;
        req_valid_v[d] = 1'b0;
        req_addr  = $urandom();
        req_wdata = $urandom();
        req_size  = 2'($urandom());
        req_write = 1'($urandom());
        lat = 1;
        while (!resp_valid_v[d] && lat < 64) begin
            @(posedge clk);
            #1;
            req_addr = $urandom();
            lat++;
        end
        check($sformatf("%s/latency", nm), 32'(lat), 32'(wait_of(d) + 1));
        check($sformatf("%s/rdata", nm), resp_rdata_v[d], exp_rd);
        check($sformatf("%s/err", nm), 32'(resp_err_v[d]), 32'(exp_err));
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("%s/hold_valid%0d", nm, k), 32'(resp_valid_v[d]), 32'd1);
            check($sformatf("%s/hold_rdata%0d", nm, k), resp_rdata_v[d], exp_rd);
            check($sformatf("%s/hold_ready%0d", nm, k), 32'(req_ready_v[d]), 32'd0);
        end
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        check($sformatf("%s/done_valid", nm), 32'(resp_valid_v[d]), 32'd0);
        check($sformatf("%s/done_ready", nm), 32'(req_ready_v[d]), 32'd1);
        check($sformatf("%s/done_rdata", nm), resp_rdata_v[d], 32'h0);
    endtask

    task automatic check_reset_outputs(input int d, input string nm);
        check($sformatf("%s/req_ready", nm), 32'(req_ready_v[d]), 32'd1);
        check($sformatf("%s/resp_valid", nm), 32'(resp_valid_v[d]), 32'd0);
        check($sformatf("%s/resp_rdata", nm), resp_rdata_v[d], 32'h0);
        check($sformatf("%s/resp_err", nm), 32'(resp_err_v[d]), 32'd0);
    endtask

    initial begin
        logic [31:0] er_rd;
        logic        er_err;
        logic [31:0] a;
        logic [31:0] wd;
        logic [1:0]  sz;
        logic        wr;
        int          d;

        rst_n       = 1'b0;
        req_valid_v = 3'b000;
        req_addr    = 32'h0;
        req_write   = 1'b0;
        req_size    = 2'b00;
        req_wdata   = 32'h0;
        resp_ready  = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) check_reset_outputs(i, $sformatf("reset%0d", i));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // Directed vectors: {inst, write, size, addr, wdata, hold, rdata, err}
        vt[0]  = '{0, 1'b1, 2'd2, 32'h004, 32'hABCD_ABCD, 0, 32'h0,         1'b0};
        vt[1]  = '{0, 1'b0, 2'd2, 32'h004, 32'h0,         0, 32'hABCD_ABCD, 1'b0};
        vt[2]  = '{0, 1'b1, 2'd2, 32'h008, 32'h1122_3344, 0, 32'h0,         1'b0};
        vt[3]  = '{0, 1'b1, 2'd0, 32'h009, 32'h0000_00EF, 0, 32'h0,         1'b0};
        vt[4]  = '{0, 1'b0, 2'd2, 32'h008, 32'h0,         0, 32'h1122_EF44, 1'b0};
        vt[5]  = '{0, 1'b0, 2'd0, 32'h00B, 32'h0,         0, 32'h0000_0011, 1'b0};
        vt[6]  = '{0, 1'b0, 2'd1, 32'h00A, 32'h0,         0, 32'h0000_1122, 1'b0};
        vt[7]  = '{0, 1'b0, 2'd1, 32'h005, 32'h0,         0, 32'h0,         1'b1};
        vt[8]  = '{0, 1'b1, 2'd2, 32'h006, 32'hFFFF_FFFF, 0, 32'h0,         1'b1};
        vt[9]  = '{0, 1'b0, 2'd2, 32'h100, 32'h0,         0, 32'h0,         1'b1};
        vt[10] = '{0, 1'b0, 2'd3, 32'h004, 32'h0,         0, 32'h0,         1'b1};
        vt[11] = '{0, 1'b0, 2'd2, 32'h004, 32'h0,         0, 32'hABCD_ABCD, 1'b0};
        vt[12] = '{0, 1'b0, 2'd2, 32'h008, 32'h0,         5, 32'h1122_EF44, 1'b0};
        vt[13] = '{1, 1'b1, 2'd2, 32'h004, 32'h55AA_C3E1, 0, 32'h0,         1'b0};
        vt[14] = '{1, 1'b0, 2'd1, 32'h006, 32'h0,         5, 32'h0000_55AA, 1'b0};
        vt[15] = '{2, 1'b1, 2'd2, 32'h43C, 32'h0,         0, 32'h0,         1'b0};
        vt[16] = '{2, 1'b1, 2'd0, 32'h43F, 32'h0000_0077, 0, 32'h0,         1'b0};
        vt[17] = '{2, 1'b0, 2'd2, 32'h43C, 32'h0,         0, 32'h7700_0000, 1'b0};
        vt[18] = '{2, 1'b0, 2'd1, 32'h43E, 32'h0,         3, 32'h0000_7700, 1'b0};
        vt[19] = '{2, 1'b0, 2'd2, 32'h3FC, 32'h0,         0, 32'h0,         1'b1};
        vt[20] = '{2, 1'b0, 2'd2, 32'h440, 32'h0,         0, 32'h0,         1'b1};
        vt[21] = '{2, 1'b0, 2'd0, 32'h43D, 32'h0,         0, 32'h0,         1'b0};

        for (int i = 0; i < 22; i++) begin
            do_req(vt[i].d, vt[i].wr, vt[i].sz, vt[i].addr, vt[i].wd, vt[i].hold,
                   vt[i].exp_rd, vt[i].exp_err, $sformatf("vec%0d", i));
            model_op(vt[i].d, vt[i].wr, vt[i].sz, vt[i].addr, vt[i].wd, er_rd, er_err);
        end

        // Reset during BUSY aborts the store; the earlier value survives
        do_req(1, 1'b1, 2'd2, 32'h00C, 32'h0, 0, 32'h0, 1'b0, "rst_pre");
        model_op(1, 1'b1, 2'd2, 32'h00C, 32'h0, er_rd, er_err);
        @(negedge clk);
        req_addr       = 32'h00C;
        req_write      = 1'b1;
        req_size       = 2'd2;
        req_wdata      = 32'hDEAD_BEEF;
        req_valid_v[1] = 1'b1;
        @(posedge clk);
        #1;
        req_valid_v[1] = 1'b0;
        @(posedge clk);
        #1;
        check("rst_busy/req_ready", 32'(req_ready_v[1]), 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs(1, "rst_async");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        do_req(1, 1'b0, 2'd2, 32'h00C, 32'h0, 0, 32'h0, 1'b0, "rst_load");

        // Fill every word of each instance so the model is fully defined
        for (int i = 0; i < 3; i++) begin
            for (int w = 0; w < depth_of(i); w++) begin
                a  = base_of(i) + 32'(4 * w);
                wd = $urandom();
                model_op(i, 1'b1, 2'd2, a, wd, er_rd, er_err);
                do_req(i, 1'b1, 2'd2, a, wd, 0, er_rd, er_err, "fill");
            end
        end

        // Randomised traffic against the model
        for (int n = 0; n < 250; n++) begin
            d  = $urandom_range(0, 2);
            wr = 1'($urandom_range(0, 1));
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a  = base_of(d) + 32'($urandom_range(0, depth_of(d) * 4 + 7));
            if ($urandom_range(0, 15) == 0) a = $urandom();
            wd = $urandom();
            model_op(d, wr, sz, a, wd, er_rd, er_err);
            do_req(d, wr, sz, a, wd, $urandom_range(0, 2), er_rd, er_err, $sformatf("rnd%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
